// File: rtl/ysyx_23060124_exu_stage_pkg.sv
// Shared constants for the execute stage: widths, ALU opcodes, control-type
// encodings and the result-register state type.
package ysyx_23060124_exu_stage_pkg;

    localparam int ISA_WIDTH = 32;
    localparam int OPT_WIDTH = 4;
    localparam int BR_WIDTH  = 3;

    // ALU opcodes understood by the sibling ALU
    localparam logic [OPT_WIDTH-1:0] OPT_EXU_ADD = 4'd0;
    localparam logic [OPT_WIDTH-1:0] OPT_EXU_SUB = 4'd1;
    localparam logic [OPT_WIDTH-1:0] OPT_EXU_SLT = 4'd2;
    localparam logic [OPT_WIDTH-1:0] OPT_EXU_AND = 4'd3;
    localparam logic [OPT_WIDTH-1:0] OPT_EXU_OR  = 4'd4;
    localparam logic [OPT_WIDTH-1:0] OPT_EXU_XOR = 4'd5;

    // Control-flow type carried with each decoded instruction
    localparam logic [BR_WIDTH-1:0] BR_NONE = 3'd0;
    localparam logic [BR_WIDTH-1:0] BR_BEQ  = 3'd1;
    localparam logic [BR_WIDTH-1:0] BR_BNE  = 3'd2;
    localparam logic [BR_WIDTH-1:0] BR_BLT  = 3'd3;
    localparam logic [BR_WIDTH-1:0] BR_BGE  = 3'd4;
    localparam logic [BR_WIDTH-1:0] BR_JAL  = 3'd5;
    localparam logic [BR_WIDTH-1:0] BR_JALR = 3'd6;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } exu_state_e;

    // Conditional branches write nothing back and produce a zero result
    function automatic logic is_cond_br(input logic [BR_WIDTH-1:0] br);
        return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_BLT) || (br == BR_BGE);
    endfunction

endpackage

// File: rtl/ysyx_23060124_br_resolve.sv
// Combinational branch/jump resolution: taken decision and redirect target.
// Conditional branches reuse the ALU result (SUB for EQ/NE, SLT for LT/GE);
// targets come from dedicated adders so the ALU stays free for the compare.
import ysyx_23060124_exu_stage_pkg::*;

module ysyx_23060124_br_resolve #(
    parameter int XLEN = ISA_WIDTH
) (
    input  logic [BR_WIDTH-1:0] br,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     alu_res,
    output logic                taken,
    output logic [XLEN-1:0]     target
);

    logic [XLEN-1:0] pc_sum_s;
    logic [XLEN-1:0] reg_sum_s;

    assign pc_sum_s  = pc + imm;
    assign reg_sum_s = rs1 + imm;

    // Decide taken and pick the target for the current control type
    always_comb begin
        taken  = 1'b0;
        target = pc_sum_s;
        case (br)
            BR_BEQ:  taken = (alu_res == {XLEN{1'b0}});
            BR_BNE:  taken = (alu_res != {XLEN{1'b0}});
            BR_BLT:  taken = alu_res[0];
            BR_BGE:  taken = ~alu_res[0];
            BR_JAL:  taken = 1'b1;
            BR_JALR: begin
                taken  = 1'b1;
                target = {reg_sum_s[XLEN-1:1], 1'b0};
            end
            default: begin
                taken  = 1'b0;
                target = pc_sum_s;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060124_exu_stage.sv
// Execute stage: operand selection for the external ALU, branch resolution,
// single-entry result register with valid/ready on both sides, and a
// one-cycle redirect pulse to the fetch unit for taken control flow.
import ysyx_23060124_exu_stage_pkg::*;

module ysyx_23060124_exu_stage #(
    parameter int XLEN = ISA_WIDTH,
    parameter int OPTW = OPT_WIDTH
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_rs1,
    input  logic [XLEN-1:0]     in_rs2,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [OPTW-1:0]     in_opt,
    input  logic                in_unsigned,
    input  logic                in_src1_pc,
    input  logic                in_src2_imm,
    input  logic [BR_WIDTH-1:0] in_br,
    input  logic [4:0]          in_rd,
    input  logic                in_wen,
    output logic [XLEN-1:0]     alu_src1,
    output logic [XLEN-1:0]     alu_src2,
    output logic [OPTW-1:0]     alu_opt,
    output logic                alu_unsigned,
    input  logic [XLEN-1:0]     alu_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [XLEN-1:0]     out_rs2,
    output logic [4:0]          out_rd,
    output logic                out_wen,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc
);

    exu_state_e      state_r;
    logic            accept_s;
    logic            taken_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] link_s;
    logic [XLEN-1:0] result_s;
    logic            wen_s;

    // Operand muxing is purely combinational from the decoded inputs
    assign alu_src1     = in_src1_pc  ? in_pc  : in_rs1;
    assign alu_src2     = in_src2_imm ? in_imm : in_rs2;
    assign alu_opt      = in_opt;
    assign alu_unsigned = in_unsigned;

    // A flush blocks acceptance; otherwise accept when empty or draining
    assign in_ready  = ~flush & ((state_r == ST_EMPTY) | out_ready);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_r == ST_FULL);

    assign link_s = in_pc + {{(XLEN-3){1'b0}}, 3'd4};

    ysyx_23060124_br_resolve #(
        .XLEN (XLEN)
    ) u_br_resolve (
        .br      (in_br),
        .pc      (in_pc),
        .rs1     (in_rs1),
        .imm     (in_imm),
        .alu_res (alu_res),
        .taken   (taken_s),
        .target  (target_s)
    );

    // Select the writeback value and write enable by control type
    always_comb begin
        result_s = alu_res;
        wen_s    = in_wen;
        case (in_br)
            BR_JAL, BR_JALR: begin
                result_s = link_s;
                wen_s    = in_wen;
            end
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE: begin
                result_s = {XLEN{1'b0}};
                wen_s    = 1'b0;
            end
            default: begin
                result_s = alu_res;
                wen_s    = in_wen;
            end
        endcase
    end

    // Result-register FSM with registered payload and redirect pulse
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_EMPTY;
            out_result     <= {XLEN{1'b0}};
            out_rs2        <= {XLEN{1'b0}};
            out_rd         <= 5'd0;
            out_wen        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= {XLEN{1'b0}};
        end else if (flush) begin
            state_r        <= ST_EMPTY;
            redirect_valid <= 1'b0;
        end else if (accept_s) begin
            state_r        <= ST_FULL;
            out_result     <= result_s;
            out_rs2        <= in_rs2;
            out_rd         <= in_rd;
            out_wen        <= wen_s & ~is_cond_br(in_br);
            redirect_valid <= taken_s;
            redirect_pc    <= target_s;
        end else begin
            redirect_valid <= 1'b0;
            case (state_r)
                ST_FULL: begin
                    if (out_ready) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                ST_EMPTY: state_r <= ST_EMPTY;
                default:  state_r <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_exu_stage.sv
// Directed bench for the execute stage with a small behavioural ALU sibling.
import ysyx_23060124_exu_stage_pkg::*;

module tb_ysyx_23060124_exu_stage;

    logic        clock;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [3:0]  in_opt;
    logic        in_unsigned, in_src1_pc, in_src2_imm;
    logic [2:0]  in_br;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_opt;
    logic        alu_unsigned;
    logic [31:0] alu_res;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_rs2;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_23060124_exu_stage dut (
        .clock(clock), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_opt(in_opt), .in_unsigned(in_unsigned),
        .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm),
        .in_br(in_br), .in_rd(in_rd), .in_wen(in_wen),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_opt(alu_opt),
        .alu_unsigned(alu_unsigned), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_wen(out_wen), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sibling ALU model
    always_comb begin
        case (alu_opt)
            OPT_EXU_ADD: alu_res = alu_src1 + alu_src2;
            OPT_EXU_SUB: alu_res = alu_src1 - alu_src2;
            OPT_EXU_SLT: alu_res = alu_unsigned ? {31'd0, (alu_src1 < alu_src2)}
                                                : {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
            default:     alu_res = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [3:0] opt, input logic uns,
                         input logic s1pc, input logic s2imm, input logic [2:0] br,
                         input logic [4:0] rd, input logic wen);
        in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_opt = opt; in_unsigned = uns; in_src1_pc = s1pc; in_src2_imm = s2imm;
        in_br = br; in_rd = rd; in_wen = wen;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, OPT_EXU_ADD, 1'b0, 1'b0, 1'b0, BR_NONE, 5'd0, 1'b0);
        in_valid = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        #1;

        // ADD 5+7 -> rd3
        out_ready = 1'b1;
        drive(32'h100, 32'd5, 32'd7, 32'd99, OPT_EXU_ADD, 1'b0, 1'b0, 1'b0, BR_NONE, 5'd3, 1'b1);
        #1;
        check("mux_src1_rs1", alu_src1, 32'd5);
        check("mux_src2_rs2", alu_src2, 32'd7);
        tick();
        in_valid = 1'b0;
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", out_result, 32'd12);
        check("add_rd", {27'd0, out_rd}, 32'd3);
        check("add_wen", {31'd0, out_wen}, 32'd1);
        check("add_rs2", out_rs2, 32'd7);
        check("add_no_redirect", {31'd0, redirect_valid}, 32'd0);
        in_src1_pc = 1'b1; in_src2_imm = 1'b1;
        #1;
        check("mux_src1_pc", alu_src1, 32'h100);
        check("mux_src2_imm", alu_src2, 32'd99);
        tick();
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: A accepted, B waits until out_ready rises
        drive(32'h0, 32'd10, 32'd20, 32'd0, OPT_EXU_ADD, 1'b0, 1'b0, 1'b0, BR_NONE, 5'd1, 1'b1);
        tick();
        out_ready = 1'b0;
        drive(32'h0, 32'd100, 32'd0, 32'd1, OPT_EXU_ADD, 1'b0, 1'b0, 1'b1, BR_NONE, 5'd2, 1'b1);
        #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_result", out_result, 32'd30);
        check("bp_hold_rd", {27'd0, out_rd}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_result", out_result, 32'd101);
        check("bp_second_rd", {27'd0, out_rd}, 32'd2);
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // BLTU 1 <u 0xFFFFFFFF taken
        drive(32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h10, OPT_EXU_SLT, 1'b1, 1'b0, 1'b0, BR_BLT, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("bltu_redirect", {31'd0, redirect_valid}, 32'd1);
        check("bltu_target", redirect_pc, 32'h80000010);
        check("bltu_wen", {31'd0, out_wen}, 32'd0);
        check("bltu_result", out_result, 32'd0);
        tick();
        check("bltu_pulse_once", {31'd0, redirect_valid}, 32'd0);
        check("bltu_stall_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();

        // BEQ 3 vs 4 not taken, then BNE taken with backward wrap target
        drive(32'h100, 32'd3, 32'd4, 32'hFFFFFFF8, OPT_EXU_SUB, 1'b0, 1'b0, 1'b0, BR_BEQ, 5'd0, 1'b0);
        tick();
        check("beq_not_taken", {31'd0, redirect_valid}, 32'd0);
        in_br = BR_BNE;
        tick();
        in_valid = 1'b0;
        check("bne_taken", {31'd0, redirect_valid}, 32'd1);
        check("bne_target", redirect_pc, 32'h000000F8);
        tick();

        // JALR clears bit 0 of rs1+imm, links pc+4
        drive(32'h80000020, 32'h80000103, 32'd0, 32'd4, OPT_EXU_ADD, 1'b0, 1'b0, 1'b1, BR_JALR, 5'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        check("jalr_target", redirect_pc, 32'h80000106);
        check("jalr_link", out_result, 32'h80000024);
        check("jalr_wen", {31'd0, out_wen}, 32'd1);
        tick();

        // Flush while FULL and stalled, with a JAL pending on the input
        drive(32'h0, 32'd1, 32'd1, 32'd0, OPT_EXU_ADD, 1'b0, 1'b0, 1'b0, BR_NONE, 5'd4, 1'b1);
        tick();
        out_ready = 1'b0; flush = 1'b1;
        drive(32'h300, 32'd0, 32'd0, 32'h20, OPT_EXU_ADD, 1'b0, 1'b0, 1'b1, BR_JAL, 5'd1, 1'b1);
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_empty", {31'd0, out_valid}, 32'd0);
        check("flush_no_redirect", {31'd0, redirect_valid}, 32'd0);

        // JAL then asynchronous reset while FULL
        out_ready = 1'b0;
        drive(32'h200, 32'd0, 32'd0, 32'h40, OPT_EXU_ADD, 1'b0, 1'b0, 1'b1, BR_JAL, 5'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("jal_redirect", {31'd0, redirect_valid}, 32'd1);
        check("jal_target", redirect_pc, 32'h240);
        check("jal_link", out_result, 32'h204);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'd0, out_valid}, 32'd0);
        check("areset_redirect", {31'd0, redirect_valid}, 32'd0);
        check("areset_result", out_result, 32'd0);
        check("areset_redirect_pc", redirect_pc, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_exu_stage.md
Name: ysyx_23060124_exu_stage

Overview:
- Execute stage between IDU (upstream) and LSU/WBU (downstream).
- Accepts one decoded instruction per valid/ready handshake and selects ALU operands.
- Drives the combinational ALU, resolves branches and jumps, and holds the result in a single-entry output register with its own valid/ready handshake.
- Issues a one-cycle redirect pulse to IFU for taken control flow.

Parameters:
- XLEN, 32, datapath width; equals `ysyx_23060124_ISA_WIDTH.
- OPTW, 4, ALU opcode width; equals `ysyx_23060124_OPT_WIDTH.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard held entry; block acceptance this cycle.
- in_valid  in  1  IDU has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1  in  XLEN  rs1 value.
- in_rs2  in  XLEN  rs2 value.
- in_imm  in  XLEN  sign-extended immediate.
- in_opt  in  OPTW  ALU opcode.
- in_unsigned  in  1  unsigned compare/sub.
- in_src1_pc  in  1  ALU src1 = pc instead of rs1.
- in_src2_imm  in  1  ALU src2 = imm instead of rs2.
- in_br  in  3  control type: 0 none, 1 BEQ, 2 BNE, 3 BLT(U), 4 BGE(U), 5 JAL, 6 JALR.
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable.
- alu_src1  out  XLEN  to ALU.
- alu_src2  out  XLEN  to ALU.
- alu_opt  out  OPTW  to ALU.
- alu_unsigned  out  1  to ALU.
- alu_res  in  XLEN  from ALU, combinational.
- out_valid  out  1  result register holds an entry.
- out_ready  in  1  downstream accepts.
- out_result  out  XLEN  writeback value.
- out_rs2  out  XLEN  store data passthrough.
- out_rd  out  5  passthrough.
- out_wen  out  1  passthrough.
- redirect_valid  out  1  one-cycle taken-branch/jump pulse.
- redirect_pc  out  XLEN  target.

Behaviour:
- Reset:
  - Asynchronous assertion of rst_n=0 clears out_valid, redirect_valid, out_result, out_rs2, out_rd, out_wen and redirect_pc to 0 immediately.
  - Reset mid-operation drops any held entry.
- FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - in_ready = !flush && (EMPTY || out_ready).
  - accept = in_valid && in_ready.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready && !accept.
  - FULL -> FULL on out_ready && accept, giving back-to-back throughput of 1 instruction/cycle.
  - FULL holds all outputs stable while out_ready=0.
  - flush forces EMPTY next cycle regardless of out_ready or in_valid. It also suppresses redirect_valid on the next edge.
- Operand muxing is combinational from the in_* ports:
  - alu_src1 = in_src1_pc ? in_pc : in_rs1.
  - alu_src2 = in_src2_imm ? in_imm : in_rs2.
  - alu_opt and alu_unsigned pass through.
  - The ALU result is sampled only on accept. Latency is 1 cycle from accept edge to out_valid=1.
- Branch resolution (IDU sets in_opt=SUB for BEQ/BNE and SLT for BLT/BGE, with src2=rs2):
  - BEQ taken iff alu_res==0.
  - BNE taken iff alu_res!=0.
  - BLT taken iff alu_res[0]==1.
  - BGE taken iff alu_res[0]==0.
  - JAL and JALR are always taken.
- Targets:
  - Branch/JAL: in_pc+in_imm, using a dedicated adder.
  - JALR: (in_rs1+in_imm) with bit 0 cleared.
  - All sums wrap modulo 2^XLEN.
- out_result:
  - JAL/JALR: in_pc+4.
  - Conditional branches: 0, and out_wen is forced to 0.
  - Otherwise: alu_res.
- redirect_valid is 1 for exactly the cycle after an accept whose control is taken; redirect_pc is registered alongside it. A stall (out_ready=0) does not extend the pulse.
- Simultaneous flush and in_valid: no accept, no redirect.

Decomposition:
- Package para_defines.v gains:
  - BR_* encodings (3 bits).
  - ysyx_23060124_BR_WIDTH.
  - Reuses existing ISA_WIDTH, OPT_WIDTH and OPT_EXU_* constants.
- Optional sub-module ysyx_23060124_br_resolve: combinational taken/target logic.
- The ALU stays a sibling instance at the EXU top, not inside this block.

Test Plan:
- ADD: rs1=5, rs2=7, opt=ADD, rd=3, wen=1, out_ready=1 -> next cycle out_valid=1, out_result=12, out_rd=3, no redirect.
- Backpressure: two back-to-back accepts with out_ready=0 after the first -> in_ready=0, first result held stable. When out_ready rises, the second is accepted that same cycle and appears the following cycle.
- BLTU: rs1=1, rs2=0xFFFFFFFF, unsigned=1, opt=SLT, br=3, pc=0x80000000, imm=0x10 -> redirect_valid one cycle, redirect_pc=0x80000010, out_wen=0.
- JALR: rs1=0x80000103, imm=4, pc=0x80000020 -> redirect_pc=0x80000106, out_result=0x80000024.
- Flush: assert flush while FULL with out_ready=0 and in_valid=1 -> next cycle out_valid=0, in_ready=0 during the flush cycle, no redirect.
- Reset mid-operation: drop rst_n asynchronously while FULL -> out_valid and redirect_valid go to 0 before the next edge.
